// File: rtl/case_2_mul_mac_pipe.sv
// Pipelined signed multiplier / multiply-accumulate with grouped accumulation and output narrowing.
// Latency: a beat accepted at edge t loads the output register at edge t+NUM_STAGE-1 (no stall).
// Backpressure: whole-pipe stall; in_ready = !out_valid || out_ready, every stage holds while stalled.
//
// Ports: ap_clk/ap_rst_n clock and async active-low reset; in_valid/in_ready input handshake carrying
// din0/din1 signed operands, in_mode (0 mul, 1 mac) and in_last (closes a MAC group);
// out_valid/out_ready output handshake carrying dout (narrowed result) and out_ovf (did not fit).
module case_2_mul_mac_pipe #(
   parameter int DIN0_WIDTH = 13,
   parameter int DIN1_WIDTH = 5,
   parameter int DOUT_WIDTH = 13,
   parameter int ACC_WIDTH  = 24,
   parameter int NUM_STAGE  = 2,
   parameter int SATURATE   = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  in_mode,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  out_ovf
);

   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

   // Representable range of dout, expressed at accumulator width for signed compares.
   localparam logic signed [ACC_WIDTH-1:0] MAXV =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MINV =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   logic                        advance;
   logic signed [PW-1:0]        a_x, b_x, p_in;

   // Beat presented to the final (output) stage.
   logic                        fin_vld;
   logic signed [PW-1:0]        fin_prod;
   logic                        fin_mode;
   logic                        fin_last;

   logic                        out_vld_q, out_vld_d;
   logic [DOUT_WIDTH-1:0]       dout_q, dout_d;
   logic                        ovf_q, ovf_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        first_q, first_d;

   logic signed [ACC_WIDTH-1:0] prod_x, sum, nar_in;
   logic                        nar_ovf;
   logic [DOUT_WIDTH-1:0]       nar_dout;

   assign advance  = !out_vld_q || out_ready;
   assign in_ready = advance;

   // Operands are widened first so the product is computed exactly at full width.
   assign a_x  = PW'($signed(din0));
   assign b_x  = PW'($signed(din1));
   assign p_in = a_x * b_x;

   generate
      if (NUM_STAGE == 1) begin : g_nopipe
         assign fin_vld  = in_valid;
         assign fin_prod = p_in;
         assign fin_mode = in_mode;
         assign fin_last = in_last;
      end else begin : g_pipe
         localparam int NPS = NUM_STAGE - 1;
         logic [NPS-1:0]       vld_q;
         logic [NPS-1:0]       mode_q;
         logic [NPS-1:0]       last_q;
         logic signed [PW-1:0] prod_q [NPS];

         // in_ready equals advance, so in_valid on an advancing edge is an accepted beat.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               vld_q  <= '0;
               mode_q <= '0;
               last_q <= '0;
               for (int i = 0; i < NPS; i++) begin
                  prod_q[i] <= '0;
               end
            end else if (advance) begin
               vld_q[0]  <= in_valid;
               mode_q[0] <= in_mode;
               last_q[0] <= in_last;
               prod_q[0] <= p_in;
               for (int i = 1; i < NPS; i++) begin
                  vld_q[i]  <= vld_q[i-1];
                  mode_q[i] <= mode_q[i-1];
                  last_q[i] <= last_q[i-1];
                  prod_q[i] <= prod_q[i-1];
               end
            end
         end

         assign fin_vld  = vld_q[NPS-1];
         assign fin_prod = prod_q[NPS-1];
         assign fin_mode = mode_q[NPS-1];
         assign fin_last = last_q[NPS-1];
      end
   endgenerate

   // Accumulation wraps silently at ACC_WIDTH; the first beat of a group ignores the old total.
   assign prod_x = ACC_WIDTH'(fin_prod);
   assign sum    = (first_q ? '0 : acc_q) + prod_x;
   assign nar_in = fin_mode ? sum : prod_x;

   assign nar_ovf  = (nar_in > MAXV) || (nar_in < MINV);
   assign nar_dout = (SATURATE != 0 && nar_ovf)
                     ? (nar_in[ACC_WIDTH-1] ? MINV[DOUT_WIDTH-1:0] : MAXV[DOUT_WIDTH-1:0])
                     : nar_in[DOUT_WIDTH-1:0];

   always_comb begin
      out_vld_d = out_vld_q;
      dout_d    = dout_q;
      ovf_d     = ovf_q;
      acc_d     = acc_q;
      first_d   = first_q;
      if (advance) begin
         // Anything held has been consumed (or there was nothing); reload only on a real result.
         out_vld_d = 1'b0;
         if (fin_vld) begin
            if (fin_mode) begin
               acc_d   = sum;
               first_d = fin_last;
            end
            if (!fin_mode || fin_last) begin
               out_vld_d = 1'b1;
               dout_d    = nar_dout;
               ovf_d     = nar_ovf;
            end
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_vld_q <= 1'b0;
         dout_q    <= '0;
         ovf_q     <= 1'b0;
         acc_q     <= '0;
         first_q   <= 1'b1;
      end else begin
         out_vld_q <= out_vld_d;
         dout_q    <= dout_d;
         ovf_q     <= ovf_d;
         acc_q     <= acc_d;
         first_q   <= first_d;
      end
   end

   assign out_valid = out_vld_q;
   assign dout      = dout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_case_2_mul_mac_pipe.sv
// Directed bench for case_2_mul_mac_pipe: a saturating and a wrapping instance share all inputs;
// delivered results are collected at the falling edge and compared with hand-computed values.
module tb_case_2_mul_mac_pipe;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, in_ready_w;
   logic [12:0] din0 = '0;
   logic [4:0]  din1 = '0;
   logic        in_mode = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid, out_valid_w;
   logic        out_ready = 1'b1;
   logic [12:0] dout, dout_w;
   logic        out_ovf, out_ovf_w;

   int n_vec = 0;
   int n_bad = 0;

   int got_d[$];
   int got_o[$];
   int gw_d[$];
   int gw_o[$];

   case_2_mul_mac_pipe #(.SATURATE(1)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .din0(din0), .din1(din1), .in_mode(in_mode), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_ovf(out_ovf)
   );

   case_2_mul_mac_pipe #(.SATURATE(0)) dut_w (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .din0(din0), .din1(din1), .in_mode(in_mode), .in_last(in_last),
      .out_valid(out_valid_w), .out_ready(out_ready), .dout(dout_w), .out_ovf(out_ovf_w)
   );

   always #5 ap_clk = ~ap_clk;

   always @(negedge ap_clk) begin
      if (ap_rst_n && out_valid && out_ready) begin
         got_d.push_back(int'($signed(dout)));
         got_o.push_back(int'(out_ovf));
      end
      if (ap_rst_n && out_valid_w && out_ready) begin
         gw_d.push_back(int'($signed(dout_w)));
         gw_o.push_back(int'(out_ovf_w));
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      got_d.delete(); got_o.delete(); gw_d.delete(); gw_o.delete();
   endtask

   // Holds the beat until an edge where in_ready was high; returns at that edge + 1.
   task automatic send(input int a, input int b, input bit m, input bit l);
      bit acc;
      int n;
      din0 = 13'(a); din1 = 5'(b); in_mode = m; in_last = l; in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge ap_clk);
         acc = in_ready;
         @(posedge ap_clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("send_accept", int'(acc), 1);
   endtask

   task automatic drain();
      repeat (8) @(posedge ap_clk);
      #1;
   endtask

   int a5[8] = '{1, 2, 3, -4, 50, 60, 7, -8};
   int b5[8] = '{1, -2, 3, 4, 5, -6, 7, -8};
   int e5[8] = '{1, -4, 9, -16, 250, -360, 49, 64};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset while idle
      repeat (2) @(negedge ap_clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_ovf", int'(out_ovf), 0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge ap_clk); #1;

      // 2. single multiply, one pulse
      clear_q();
      send(100, -3, 1'b0, 1'b0);
      drain();
      chk("t2_count", got_d.size(), 1);
      if (got_d.size() >= 1) begin
         chk("t2_dout", got_d[0], -300);
         chk("t2_ovf", got_o[0], 0);
      end

      // 3. overflow corners, saturating and wrapping
      clear_q();
      send(4095, 15, 1'b0, 1'b0);
      send(-4096, -16, 1'b0, 1'b0);
      send(-4096, 15, 1'b0, 1'b0);
      drain();
      chk("t3_count", got_d.size(), 3);
      chk("t3w_count", gw_d.size(), 3);
      if (got_d.size() == 3 && gw_d.size() == 3) begin
         chk("t3_sat0", got_d[0], 4095);  chk("t3_ovf0", got_o[0], 1);
         chk("t3_sat1", got_d[1], 4095);  chk("t3_ovf1", got_o[1], 1);
         chk("t3_sat2", got_d[2], -4096); chk("t3_ovf2", got_o[2], 1);
         chk("t3_wrap0", gw_d[0], 4081);  chk("t3w_ovf0", gw_o[0], 1);
         chk("t3_wrap1", gw_d[1], 0);     chk("t3w_ovf1", gw_o[1], 1);
         chk("t3_wrap2", gw_d[2], -4096); chk("t3w_ovf2", gw_o[2], 1);
      end

      // 4. two MAC groups
      clear_q();
      send(10, 3, 1'b1, 1'b0);
      send(20, -2, 1'b1, 1'b0);
      send(7, 5, 1'b1, 1'b1);
      send(1, 1, 1'b1, 1'b1);
      drain();
      chk("t4_count", got_d.size(), 2);
      if (got_d.size() == 2) begin
         chk("t4_grp0", got_d[0], 25);
         chk("t4_ovf0", got_o[0], 0);
         chk("t4_grp1", got_d[1], 1);
      end

      // 5. streaming with a 3-cycle output stall
      clear_q();
      fork
         begin
            for (int i = 0; i < 8; i++) send(a5[i], b5[i], 1'b0, 1'b0);
         end
         begin
            int n;
            n = 0;
            while (got_d.size() < 3 && n < 100) begin
               @(posedge ap_clk);
               n++;
            end
            #1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge ap_clk);
               chk("t5_stall_in_ready", int'(in_ready), 0);
               chk("t5_stall_valid", int'(out_valid), 1);
               chk("t5_stall_dout", int'($signed(dout)), e5[got_d.size()]);
               @(posedge ap_clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("t5_count", got_d.size(), 8);
      if (got_d.size() == 8) begin
         for (int i = 0; i < 8; i++) chk($sformatf("t5_dout%0d", i), got_d[i], e5[i]);
      end

      // 6. reset in the middle of a MAC group
      clear_q();
      send(10, 3, 1'b1, 1'b0);
      send(20, -2, 1'b1, 1'b0);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      chk("t6_rst_valid", int'(out_valid), 0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      send(7, 5, 1'b1, 1'b1);
      drain();
      chk("t6_count", got_d.size(), 1);
      if (got_d.size() == 1) begin
         chk("t6_dout", got_d[0], 35);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
